reload_down_counter: RTL and testbench
======================================

RELOAD_DOWN_COUNTER -- requirements
Module: reload_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and reload width in bits.
REQ-002 SHALL have input clk, 1 bit, the clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-004 SHALL have input load_i, 1 bit, which captures load_val into the reload register and the counter.
REQ-005 SHALL have input load_val, WIDTH bits, the reload value.
REQ-006 SHALL have input start_i, 1 bit, which starts from IDLE or resumes from HOLD.
REQ-007 SHALL have input stop_i, 1 bit, which pauses the count (RUN to HOLD).
REQ-008 SHALL have input oneshot_i, 1 bit, sampled on start_i from IDLE: 1 = one-shot, 0 = periodic.
REQ-009 SHALL have output count_o, WIDTH bits, the registered current count.
REQ-010 SHALL have output tc_o, 1 bit, a registered single-cycle terminal-count pulse.
REQ-011 SHALL have output busy_o, 1 bit, high whenever state != IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and HOLD.
REQ-013 SHALL, on load_i, set reload_ff <= load_val and count <= load_val in any state; a load SHALL NOT pulse tc_o and SHALL NOT change state.
REQ-014 SHALL, when IDLE and start_i is high, set count <= reload_ff, latch the mode from oneshot_i and enter RUN; the first decrement occurs on the next tick.
REQ-015 SHALL, when RUN and a tick occurs with count != 0, decrement count by 1.
REQ-016 SHALL, when RUN and a tick occurs with count == 0 in periodic mode, set count <= reload_ff and tc_o = 1 for the next cycle, and remain in RUN.
REQ-017 SHALL, when RUN and a tick occurs with count == 0 in one-shot mode, pulse tc_o once, enter IDLE and hold count at 0.
REQ-018 SHALL give a periodic tc_o period of reload_ff+1 ticks; reload_ff = 0 SHALL give tc_o high on every tick.
REQ-019 SHALL, on stop_i in RUN, enter HOLD with count frozen; stop_i in IDLE or HOLD SHALL be ignored.
REQ-020 SHALL, on start_i in HOLD, re-enter RUN and continue from the frozen count without reloading; start_i in RUN SHALL be ignored.
REQ-021 SHALL give stop_i priority over start_i when both are high.
REQ-022 SHALL, when load_i coincides with start_i or stop_i, apply the load first and then evaluate the state transition using the loaded value; when load_i coincides with start_i in IDLE, count SHALL equal load_val.
REQ-023 SHALL treat load_i as overriding the decrement and the terminal-count evaluation in the same cycle.
REQ-024 SHALL perform all arithmetic modulo 2^WIDTH; count never underflows because of the zero check.

Reset
REQ-025 SHALL, on reset, set count_o = 0, reload_ff = 0, tc_o = 0, busy_o = 0, state = IDLE, mode = periodic and prescaler = 0, asynchronously.
REQ-026 SHALL, on reset asserted mid-RUN, abort the run immediately and suppress any pending tc_o pulse.

Configuration
REQ-027 SHALL, with macro RELOAD_DOWN_COUNTER_PRESCALE_EN defined, add parameter PRESCALE (default 4, minimum 1) and generate a tick once every PRESCALE clk cycles while in RUN.
REQ-028 SHALL, with the prescaler compiled in, clear the prescaler on load_i and on start_i from IDLE, and freeze it in HOLD.
REQ-029 SHALL, without RELOAD_DOWN_COUNTER_PRESCALE_EN, tick every clk cycle in RUN, with no PRESCALE parameter and no prescaler logic.

Structure
REQ-030 SHALL place the state enum (IDLE/RUN/HOLD) and the default WIDTH constant in the shared package rdc_pkg.
REQ-031 SHALL implement the prescaler as the sub-module rdc_prescaler (inputs clk, reset, clr, en; output tick), instantiated only when the macro is defined.

Verification
REQ-032 SHALL cover reset: assert reset mid-RUN at count 5 -> count_o=0, tc_o=0, busy_o=0 on the same cycle.
REQ-033 SHALL cover periodic mode: WIDTH=4, load 3, start (oneshot_i=0) -> count_o 3,2,1,0,3,2,...; tc_o high only in the cycles where count_o returns to 3.
REQ-034 SHALL cover one-shot mode: load 2, start (oneshot_i=1) -> count_o 2,1,0; one tc_o pulse; busy_o drops with tc_o; count_o stays 0.
REQ-035 SHALL cover pause and resume: load 9, start, stop at count_o=5, hold 3 cycles -> count_o stays 5; start -> next count_o=4; no reload.
REQ-036 SHALL cover simultaneous events: in RUN at count_o=7, load_i with load_val=12 plus stop_i -> count_o=12, state HOLD, tc_o=0; start_i+stop_i in HOLD -> stays HOLD.
REQ-037 SHALL cover the prescaler: with the macro defined, PRESCALE=4, load 1, start -> count_o changes every 4 cycles; tc_o period is 8 cycles.

Source files
------------

// File: rtl/rdc_pkg.sv
// Shared types and defaults for the reload down-counter.
// The FSM encoding and default width live here so every file agrees.
package rdc_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } rdc_state_t;

    localparam int RDC_WIDTH_DEF = 4;
endpackage

// File: rtl/rdc_prescaler.sv
// Tick generator: one tick every PRESCALE enabled cycles, cleared by clr.
// Only built when RELOAD_DOWN_COUNTER_PRESCALE_EN is defined.
module rdc_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/reload_down_counter.sv
// Down-counter with reload register, periodic/one-shot modes and pause/resume.
// Optional clock prescaler enabled by RELOAD_DOWN_COUNTER_PRESCALE_EN.
module reload_down_counter
    import rdc_pkg::*;
#(
    parameter int WIDTH = RDC_WIDTH_DEF
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    , parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             oneshot_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o
);
    rdc_state_t       state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic [WIDTH-1:0] reload_ff, reload_next;
    logic             mode_ff, mode_next;
    logic             tc_ff, tc_next;
    logic             tick;
    logic             start_idle;
    logic             expire;

    // stop has priority over start in every state
    assign start_idle = (state == IDLE) && start_i && !stop_i;
    // a load in the same cycle suppresses decrement and terminal count
    assign expire     = (state == RUN) && !stop_i && !load_i && tick && (count == '0);

`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    rdc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load_i || start_idle),
        .en    ((state == RUN) && !stop_i),
        .tick  (tick)
    );
`else
    assign tick = (state == RUN);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_i && !stop_i) state_next = RUN;
            RUN: begin
                if (stop_i)
                    state_next = HOLD;
                else if (expire && mode_ff)
                    state_next = IDLE;
            end
            HOLD: if (start_i && !stop_i) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state != IDLE);
        count_o = count;
        tc_o    = tc_ff;
    end

    always_comb begin
        reload_next = reload_ff;
        count_next  = count;
        mode_next   = mode_ff;
        tc_next     = 1'b0;
        if (load_i) begin
            reload_next = load_val;
            count_next  = load_val;
        end
        if (start_idle) begin
            mode_next = oneshot_i;
            if (!load_i)
                count_next = reload_ff;
        end
        if ((state == RUN) && !stop_i && !load_i && tick) begin
            if (count != '0) begin
                count_next = count - 1'b1;
            end else begin
                tc_next    = 1'b1;
                count_next = mode_ff ? '0 : reload_ff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            reload_ff <= '0;
            mode_ff   <= 1'b0;
            tc_ff     <= 1'b0;
        end else begin
            count     <= count_next;
            reload_ff <= reload_next;
            mode_ff   <= mode_next;
            tc_ff     <= tc_next;
        end
    end
endmodule

// File: tb/tb_reload_down_counter.sv
// Self-checking bench for reload_down_counter: directed scenarios plus random
// stimulus checked every cycle against a behavioural model.
module tb_reload_down_counter;
    localparam int W = 4;
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_i = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic         oneshot_i = 1'b0;
    logic [W-1:0] count_o;
    logic         tc_o;
    logic         busy_o;

    int n_chk = 0;
    int n_err = 0;

    // model: 0 = idle, 1 = running, 2 = paused
    int           m_state = 0;
    logic [W-1:0] m_cnt = '0;
    logic [W-1:0] m_rel = '0;
    bit           m_one = 0;
    bit           m_tc = 0;
    int           m_run_cycles = 0;

    reload_down_counter #(
        .WIDTH (W)
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
        , .PRESCALE (P)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_i),
        .load_val  (load_val),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .oneshot_i (oneshot_i),
        .count_o   (count_o),
        .tc_o      (tc_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = '0; m_rel = '0; m_one = 0; m_tc = 0; m_run_cycles = 0;
    endtask

    // One clock of the specified behaviour; ticks fall on every P-th running cycle.
    task automatic model_clk(input bit ld, input logic [W-1:0] lv, input bit st,
                             input bit sp, input bit os);
        bit go;
        m_tc = 0;
        go = st && !sp;
        if (ld) begin
            m_rel = lv;
            m_cnt = lv;
            m_run_cycles = 0;
            if (m_state == 0 && go) begin m_state = 1; m_one = os; end
            else if (m_state == 1 && sp) m_state = 2;
            else if (m_state == 2 && go) m_state = 1;
        end else if (m_state == 0) begin
            if (go) begin m_state = 1; m_one = os; m_cnt = m_rel; m_run_cycles = 0; end
        end else if (m_state == 2) begin
            if (go) m_state = 1;
        end else if (sp) begin
            m_state = 2;
        end else begin
            m_run_cycles++;
            if (m_run_cycles % P == 0) begin
                if (m_cnt != 0) m_cnt = m_cnt - 1;
                else begin
                    m_tc = 1;
                    if (m_one) begin m_state = 0; m_cnt = 0; end
                    else m_cnt = m_rel;
                end
            end
        end
    endtask

    task automatic step(input bit ld, input logic [W-1:0] lv, input bit st,
                        input bit sp, input bit os);
        load_i = ld; load_val = lv; start_i = st; stop_i = sp; oneshot_i = os;
        @(posedge clk);
        model_clk(ld, lv, st, sp, os);
        #1;
        load_i = 0; start_i = 0; stop_i = 0;
        check("count", 32'(count_o), 32'(m_cnt));
        check("tc", 32'(tc_o), 32'(m_tc));
        check("busy", 32'(busy_o), 32'(m_state != 0));
    endtask

    task automatic idle_step();
        step(0, '0, 0, 0, 0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is visible before any edge.
    task automatic apply_reset();
        #2 reset = 1;
        #1;
        check("rst_count", 32'(count_o), 0);
        check("rst_tc", 32'(tc_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        int per_seq[8];
        int guard;
        per_seq = '{2, 1, 0, 3, 2, 1, 0, 3};

        repeat (2) @(posedge clk);
        #1;
        check("init_count", 32'(count_o), 0);
        check("init_tc", 32'(tc_o), 0);
        check("init_busy", 32'(busy_o), 0);
        reset = 0;

        // periodic, reload 3
        step(1, 4'd3, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        check("per_start", 32'(count_o), 3);
        for (int i = 0; i < 8; i++) begin
            repeat (P - 1) idle_step();
            idle_step();
            check("per_seq", 32'(count_o), 32'(per_seq[i]));
            check("per_tc", 32'(tc_o), 32'(per_seq[i] == 3));
        end

        // reset mid-run at count 5
        apply_reset();
        step(1, 4'd9, 1, 0, 0);
        guard = 0;
        while (m_cnt != 5 && guard < 100) begin idle_step(); guard++; end
        check("rst_reach5", 32'(count_o), 5);
        apply_reset();

        // one-shot, reload 2
        step(1, 4'd2, 0, 0, 0);
        step(0, '0, 1, 0, 1);
        guard = 0;
        while (!tc_o && guard < 100) begin idle_step(); guard++; end
        check("os_tc_seen", 32'(tc_o), 1);
        check("os_busy_drop", 32'(busy_o), 0);
        check("os_zero", 32'(count_o), 0);
        repeat (3) idle_step();
        check("os_hold_zero", 32'(count_o), 0);
        check("os_single_tc", 32'(tc_o), 0);

        // pause and resume, reload 9
        step(1, 4'd9, 1, 0, 0);
        guard = 0;
        while (m_cnt != 5 && guard < 100) begin idle_step(); guard++; end
        step(0, '0, 0, 1, 0);
        repeat (3) idle_step();
        check("hold_frozen", 32'(count_o), 5);
        check("hold_busy", 32'(busy_o), 1);
        step(0, '0, 1, 0, 0);
        repeat (P) idle_step();
        check("resume_next", 32'(count_o), 4);

        // load with stop at count 7, then start+stop while paused
        apply_reset();
        step(1, 4'd12, 1, 0, 0);
        guard = 0;
        while (m_cnt != 7 && guard < 100) begin idle_step(); guard++; end
        step(1, 4'd12, 0, 1, 0);
        check("ldstop_count", 32'(count_o), 12);
        check("ldstop_tc", 32'(tc_o), 0);
        step(0, '0, 1, 1, 0);
        repeat (2 * P) idle_step();
        check("startstop_hold", 32'(count_o), 12);

        // reload 0 periodic: terminal count on every tick
        step(1, 4'd0, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        repeat (4 * P) idle_step();
        step(0, '0, 0, 1, 0);

        // random stimulus against the model
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0)
                apply_reset();
            else
                step($urandom_range(0, 15) == 0, W'($urandom), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
